// File: rtl/axil_pkg.sv
// Shared AXI4-Lite types for the command master and its helpers.
package axil_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } resp_t;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WAIT_B,
        RD,
        WAIT_R,
        RSP
    } master_state_t;

endpackage

// File: rtl/axil_cmd_master_if.sv
// AXI4-Lite bus bundle between the command master and a slave.
interface axil_cmd_master_if #(
    parameter int AW = 4,
    parameter int DW = 32
);
    logic [AW-1:0]   AWADDR;
    logic [2:0]      AWPROT;
    logic            AWVALID;
    logic            AWREADY;
    logic [DW-1:0]   WDATA;
    logic [DW/8-1:0] WSTRB;
    logic            WVALID;
    logic            WREADY;
    logic [1:0]      BRESP;
    logic            BVALID;
    logic            BREADY;
    logic [AW-1:0]   ARADDR;
    logic [2:0]      ARPROT;
    logic            ARVALID;
    logic            ARREADY;
    logic [DW-1:0]   RDATA;
    logic [1:0]      RRESP;
    logic            RVALID;
    logic            RREADY;

    modport master (
        output AWADDR, AWPROT, AWVALID, input AWREADY,
        output WDATA, WSTRB, WVALID, input WREADY,
        input BRESP, BVALID, output BREADY,
        output ARADDR, ARPROT, ARVALID, input ARREADY,
        input RDATA, RRESP, RVALID, output RREADY
    );

    modport slave (
        input AWADDR, AWPROT, AWVALID, output AWREADY,
        input WDATA, WSTRB, WVALID, output WREADY,
        output BRESP, BVALID, input BREADY,
        input ARADDR, ARPROT, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID, input RREADY
    );
endinterface

// File: rtl/axil_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module axil_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (clr) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/axil_cmd_master.sv
// AXI4-Lite single-outstanding master: one command in, one AXI transaction
// out, one response back, plus saturating completion and error counters.
module axil_cmd_master
    import axil_pkg::*;
#(
    parameter int         C_M_AXI_ADDR_WIDTH = 4,
    parameter int         C_M_AXI_DATA_WIDTH = 32,
    parameter logic [2:0] C_PROT             = 3'b000,
    parameter int         C_CNT_WIDTH        = 16
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESET,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic                            rsp_write,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    axil_cmd_master_if.master               m_axi,
    output logic [C_CNT_WIDTH-1:0]          txn_cnt,
    output logic [C_CNT_WIDTH-1:0]          err_cnt
);
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int SW = DW / 8;

    master_state_t state_q, state_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
    logic          bready_q, bready_d, rready_q, rready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          write_q, write_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [SW-1:0] wstrb_q, wstrb_d;
    resp_t         resp_q, resp_d;
    logic          rsp_hs;

    assign rsp_hs = rsp_valid_q && rsp_ready;

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        bready_d    = bready_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rdata_d     = rdata_q;
        resp_d      = resp_q;
        unique case (state_q)
            IDLE: if (cmd_valid && cmd_ready_q) begin
                cmd_ready_d = 1'b0;
                write_d     = cmd_write;
                addr_d      = cmd_addr;
                wdata_d     = cmd_wdata;
                wstrb_d     = cmd_wstrb;
                rdata_d     = '0;
                resp_d      = OKAY;
                if (cmd_write) begin
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = WR;
                end else begin
                    arvalid_d = 1'b1;
                    state_d   = RD;
                end
            end
            // AW and W complete independently; move on once both are gone.
            WR: begin
                if (awvalid_q && m_axi.AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && m_axi.WREADY)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WAIT_B;
                end
            end
            WAIT_B: if (m_axi.BVALID && bready_q) begin
                resp_d      = resp_t'(m_axi.BRESP);
                bready_d    = 1'b0;
                rsp_valid_d = 1'b1;
                state_d     = RSP;
            end
            RD: if (m_axi.ARREADY) begin
                arvalid_d = 1'b0;
                rready_d  = 1'b1;
                state_d   = WAIT_R;
            end
            WAIT_R: if (m_axi.RVALID && rready_q) begin
                rdata_d     = m_axi.RDATA;
                resp_d      = resp_t'(m_axi.RRESP);
                rready_d    = 1'b0;
                rsp_valid_d = 1'b1;
                state_d     = RSP;
            end
            RSP: if (rsp_ready) begin
                rsp_valid_d = 1'b0;
                cmd_ready_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
            resp_q      <= OKAY;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
        end
    end

    axil_sat_counter #(.W(C_CNT_WIDTH)) u_txn_cnt (
        .clk(M_AXI_ACLK), .clr(M_AXI_ARESET), .inc(rsp_hs), .cnt(txn_cnt)
    );
    axil_sat_counter #(.W(C_CNT_WIDTH)) u_err_cnt (
        .clk(M_AXI_ACLK), .clr(M_AXI_ARESET), .inc(rsp_hs && (resp_q != OKAY)), .cnt(err_cnt)
    );

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_write     = write_q;
    assign rsp_rdata     = rdata_q;
    assign rsp_resp      = resp_q;
    assign m_axi.AWADDR  = addr_q;
    assign m_axi.AWPROT  = C_PROT;
    assign m_axi.AWVALID = awvalid_q;
    assign m_axi.WDATA   = wdata_q;
    assign m_axi.WSTRB   = wstrb_q;
    assign m_axi.WVALID  = wvalid_q;
    assign m_axi.BREADY  = bready_q;
    assign m_axi.ARADDR  = addr_q;
    assign m_axi.ARPROT  = C_PROT;
    assign m_axi.ARVALID = arvalid_q;
    assign m_axi.RREADY  = rready_q;
endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: adder-like register slave with programmable
// ready delays and response injection, plus a register/counter reference model.
module tb_axil_cmd_master;
    import axil_pkg::*;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int CW = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [SW-1:0] cmd_wstrb = '0;
    logic          rsp_valid, rsp_ready = 1'b0, rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [CW-1:0] txn_cnt, err_cnt;

    always #5 clk = ~clk;

    axil_cmd_master_if #(.AW(AW), .DW(DW)) bus ();

    axil_cmd_master #(
        .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW),
        .C_PROT(3'b000), .C_CNT_WIDTH(CW)
    ) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axi(bus), .txn_cnt(txn_cnt), .err_cnt(err_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // slave knobs (set by the sequence) and observations (kept by the slave)
    int          aw_dly = 0, w_dly = 0, ar_dly = 0;
    logic [1:0]  inj_b = 2'd0, inj_r = 2'd0;
    int          aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, ar_hs_n = 0, stab_err = 0;
    logic [DW-1:0] slv_regs [4];

    // Slave: acts on the falling edge, so everything it drives is settled
    // well before the next rising edge where the DUT samples it.
    initial begin : slave
        int aw_wait, w_wait, ar_wait;
        logic awv_s, wv_s, arv_s, bready_s, rready_s, aw_got, w_got, rd_pend;
        logic [AW-1:0] awaddr_s, araddr_s, got_addr, rd_addr;
        logic [DW-1:0] wdata_s, got_data;
        logic [SW-1:0] wstrb_s, got_strb;
        bus.AWREADY = 0; bus.WREADY = 0; bus.ARREADY = 0;
        bus.BVALID = 0; bus.BRESP = 0; bus.RVALID = 0; bus.RRESP = 0; bus.RDATA = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0;
        awv_s = 0; wv_s = 0; arv_s = 0; bready_s = 0; rready_s = 0;
        aw_got = 0; w_got = 0; rd_pend = 0;
        awaddr_s = 0; araddr_s = 0; got_addr = 0; rd_addr = 0;
        wdata_s = 0; got_data = 0; wstrb_s = 0; got_strb = 0;
        for (int i = 0; i < 4; i++) slv_regs[i] = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.AWREADY = 0; bus.WREADY = 0; bus.ARREADY = 0;
                bus.BVALID = 0; bus.RVALID = 0;
                awv_s = 0; wv_s = 0; arv_s = 0; bready_s = 0; rready_s = 0;
                aw_got = 0; w_got = 0; rd_pend = 0;
                aw_wait = aw_dly; w_wait = w_dly; ar_wait = ar_dly;
                for (int i = 0; i < 4; i++) slv_regs[i] = '0;
                continue;
            end
            if (awv_s && bus.AWREADY) begin aw_hs_n++; aw_got = 1; got_addr = awaddr_s; end
            if (wv_s && bus.WREADY) begin w_hs_n++; w_got = 1; got_data = wdata_s; got_strb = wstrb_s; end
            if (bus.BVALID && bready_s) begin b_hs_n++; bus.BVALID = 0; end
            if (arv_s && bus.ARREADY) begin ar_hs_n++; rd_pend = 1; rd_addr = araddr_s; end
            if (bus.RVALID && rready_s) bus.RVALID = 0;
            if (awv_s && !bus.AWREADY && (!bus.AWVALID || bus.AWADDR !== awaddr_s || bus.AWPROT !== 3'b000)) stab_err++;
            if (wv_s && !bus.WREADY && (!bus.WVALID || bus.WDATA !== wdata_s || bus.WSTRB !== wstrb_s)) stab_err++;
            if (arv_s && !bus.ARREADY && (!bus.ARVALID || bus.ARADDR !== araddr_s || bus.ARPROT !== 3'b000)) stab_err++;
            if (aw_got && w_got && !bus.BVALID) begin
                if (got_addr[3:2] != 2'd2)
                    for (int b = 0; b < SW; b++)
                        if (got_strb[b]) slv_regs[got_addr[3:2]][8*b +: 8] = got_data[8*b +: 8];
                bus.BVALID = 1; bus.BRESP = inj_b; aw_got = 0; w_got = 0;
            end
            if (rd_pend && !bus.RVALID) begin
                bus.RDATA = (rd_addr[3:2] == 2'd2) ? slv_regs[0] + slv_regs[1] : slv_regs[rd_addr[3:2]];
                bus.RRESP = inj_r; bus.RVALID = 1; rd_pend = 0;
            end
            if (bus.AWVALID) begin
                if (aw_wait == 0) bus.AWREADY = 1; else begin bus.AWREADY = 0; aw_wait--; end
            end else begin bus.AWREADY = 0; aw_wait = aw_dly; end
            if (bus.WVALID) begin
                if (w_wait == 0) bus.WREADY = 1; else begin bus.WREADY = 0; w_wait--; end
            end else begin bus.WREADY = 0; w_wait = w_dly; end
            if (bus.ARVALID) begin
                if (ar_wait == 0) bus.ARREADY = 1; else begin bus.ARREADY = 0; ar_wait--; end
            end else begin bus.ARREADY = 0; ar_wait = ar_dly; end
            awv_s = bus.AWVALID; awaddr_s = bus.AWADDR;
            wv_s = bus.WVALID; wdata_s = bus.WDATA; wstrb_s = bus.WSTRB;
            arv_s = bus.ARVALID; araddr_s = bus.ARADDR;
            bready_s = bus.BREADY; rready_s = bus.RREADY;
        end
    end

    // reference model: register contents as the sequence believes them
    logic [DW-1:0] exp_r [4];
    int n_txn = 0, n_err = 0;

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        int idx = int'(a) / 4;
        return (idx == 2) ? exp_r[0] + exp_r[1] : exp_r[idx];
    endfunction

    task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        logic [DW-1:0] mask = '0;
        int idx = int'(a) / 4;
        for (int b = 0; b < SW; b++) if (s[b]) mask = mask | (DW'(32'hff) << (8 * b));
        if (idx != 2) exp_r[idx] = (exp_r[idx] & ~mask) | (d & mask);
    endtask

    function automatic int sat(input int n);
        return (n > CMAX) ? CMAX : n;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        int n = 0;
        @(negedge clk);
        cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1;
        while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
        if (!cmd_ready) chk("cmd_accept_timeout", 64'd0, 64'd1);
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
        if (!rsp_valid) chk("rsp_timeout", 64'd0, 64'd1);
    endtask

    task automatic take_rsp();
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
    endtask

    task automatic do_txn(input string tag, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s, input logic [1:0] rb, input logic [1:0] rr, input bit chk_lat);
        logic [DW-1:0] erd;
        logic [1:0] eresp;
        int lat;
        inj_b = rb; inj_r = rr;
        erd   = w ? '0 : model_read(a);
        eresp = w ? rb : rr;
        send_cmd(w, a, d, s);
        if (w) model_write(a, d, s);
        wait_rsp(lat);
        if (rsp_valid) begin
            chk({tag, ".write"}, 64'(rsp_write), 64'(w));
            chk({tag, ".rdata"}, 64'(rsp_rdata), 64'(erd));
            chk({tag, ".resp"}, 64'(rsp_resp), 64'(eresp));
            if (chk_lat) chk({tag, ".latency"}, 64'(lat), 64'd3);
            take_rsp();
            n_txn++;
            if (eresp != 2'd0) n_err++;
            chk({tag, ".txn_cnt"}, 64'(txn_cnt), 64'(sat(n_txn)));
            chk({tag, ".err_cnt"}, 64'(err_cnt), 64'(sat(n_err)));
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin : seq
        int a0, w0, b0;
        logic [DW-1:0] held;
        for (int i = 0; i < 4; i++) exp_r[i] = '0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst.valids", 64'({bus.AWVALID, bus.WVALID, bus.ARVALID}), 64'd0);
        chk("rst.readies", 64'({bus.BREADY, bus.RREADY, rsp_valid}), 64'd0);
        chk("rst.counters", 64'({txn_cnt, err_cnt}), 64'd0);
        rst = 0;
        @(negedge clk);
        chk("rst.cmd_ready", 64'(cmd_ready), 64'd1);

        // operand write / readback, then adder result
        do_txn("wr_r0", 1'b1, 4'h0, 32'h0000_aaaa, 4'hf, 2'd0, 2'd0, 1'b1);
        do_txn("rd_r0", 1'b0, 4'h0, 32'h0, 4'h0, 2'd0, 2'd0, 1'b1);
        do_txn("wr_r1", 1'b1, 4'h4, 32'hbbbb_0000, 4'hf, 2'd0, 2'd0, 1'b1);
        do_txn("wr_r3", 1'b1, 4'hc, 32'h3, 4'hf, 2'd0, 2'd0, 1'b1);
        do_txn("rd_r3", 1'b0, 4'hc, 32'h0, 4'h0, 2'd0, 2'd0, 1'b1);
        do_txn("rd_r2", 1'b0, 4'h8, 32'h0, 4'h0, 2'd0, 2'd0, 1'b1);

        // AW and W accepted in different cycles, both orders
        for (int k = 0; k < 2; k++) begin
            aw_dly = (k == 0) ? 3 : 0;
            w_dly  = (k == 0) ? 0 : 3;
            a0 = aw_hs_n; w0 = w_hs_n; b0 = b_hs_n;
            do_txn(k == 0 ? "skew_aw" : "skew_w", 1'b1, 4'h0, 32'h1234_5678 + k, 4'h5, 2'd0, 2'd0, 1'b0);
            chk("skew.aw_once", 64'(aw_hs_n - a0), 64'd1);
            chk("skew.w_once", 64'(w_hs_n - w0), 64'd1);
            chk("skew.b_once", 64'(b_hs_n - b0), 64'd1);
            chk("skew.stable", 64'(stab_err), 64'd0);
        end
        aw_dly = 0; w_dly = 0;

        // error responses
        do_txn("bresp2", 1'b1, 4'h4, 32'hcafe_f00d, 4'hc, 2'd2, 2'd0, 1'b0);
        do_txn("rresp3", 1'b0, 4'h4, 32'h0, 4'h0, 2'd0, 2'd3, 1'b0);

        // response backpressure: nothing moves while rsp_ready is held low
        inj_r = 2'd0;
        send_cmd(1'b0, 4'h4, 32'h0, 4'h0);
        begin
            int lat;
            wait_rsp(lat);
        end
        held = rsp_rdata;
        a0 = ar_hs_n;
        repeat (5) begin
            @(negedge clk);
            chk("hold.rsp_valid", 64'(rsp_valid), 64'd1);
            chk("hold.rdata", 64'(rsp_rdata), 64'(held));
            chk("hold.idle_bus", 64'({cmd_ready, bus.AWVALID, bus.WVALID, bus.ARVALID}), 64'd0);
        end
        chk("hold.rdata_model", 64'(held), 64'(model_read(4'h4)));
        chk("hold.no_ar", 64'(ar_hs_n - a0), 64'd0);
        take_rsp();
        n_txn++;

        // reset while ARVALID is waiting
        ar_dly = 10;
        send_cmd(1'b0, 4'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk("mid_rst.arvalid_before", 64'(bus.ARVALID), 64'd1);
        rst = 1;
        @(negedge clk);
        chk("mid_rst.arvalid", 64'(bus.ARVALID), 64'd0);
        chk("mid_rst.rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst.cmd_ready", 64'(cmd_ready), 64'd1);
        chk("mid_rst.counters", 64'({txn_cnt, err_cnt}), 64'd0);
        rst = 0;
        ar_dly = 0;
        for (int i = 0; i < 4; i++) exp_r[i] = '0;
        n_txn = 0; n_err = 0;

        // random traffic with random slave timing and error injection
        for (int i = 0; i < 30; i++) begin
            logic [1:0] idx = 2'($urandom_range(0, 3));
            logic [1:0] rb = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            logic [1:0] rr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            aw_dly = $urandom_range(0, 3);
            w_dly  = $urandom_range(0, 3);
            ar_dly = $urandom_range(0, 3);
            do_txn("rand", 1'($urandom_range(0, 1)), {idx, 2'b00}, $urandom, 4'($urandom_range(0, 15)), rb, rr, 1'b0);
        end
        chk("rand.stable", 64'(stab_err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
